bridge_arbiter: RTL
===================

// Module: bridge_arbiter
// PURPOSE
//  Two-master arbiter that shares the single Bridge port between the CPU
//  memory stage (M0) and a secondary bus master such as DMA or debug (M1).
//  Owner state is registered; the transfer itself is combinational through
//  to the Bridge, which decodes DM / timer0 / timer1 / interrupt space.
//  Bounded-burst round-robin; neither master starves.
// PARAMETERS
//  M0_MAX_BEATS  4   consecutive acked M0 beats before yielding to a waiting M1
//  M1_MAX_BEATS  8   consecutive acked M1 beats before yielding to a waiting M0
//  CW            4   beat-counter width; must hold max(M0_MAX_BEATS,M1_MAX_BEATS)
// PORTS
//  clk          in   1   system clock, rising edge
//  rst_n        in   1   asynchronous reset, active low
//  m0_req       in   1   M0 requests an access this cycle
//  m0_addr      in   32  M0 byte address
//  m0_wdata     in   32  M0 write data
//  m0_we        in   1   M0 write enable
//  m0_be        in   4   M0 byte enables
//  m0_ack       out  1   M0 access performed this cycle
//  m0_rdata     out  32  read data to M0; valid when m0_ack=1
//  m1_req / m1_addr / m1_wdata / m1_we / m1_be   in   as M0, for M1
//  m1_ack       out  1   M1 access performed this cycle
//  m1_rdata     out  32  read data to M1; valid when m1_ack=1
//  br_addr      out  32  to Bridge cpu_addr
//  br_wdata     out  32  to Bridge cpu_writedata
//  br_we        out  1   to Bridge cpu_we
//  br_be        out  4   to Bridge cpu_be
//  br_rdata     in   32  from Bridge cpu_readdata
//  owner        out  1   current owner; 0 = M0, 1 = M1
// BEHAVIOUR
//  - State: owner (OWN0 / OWN1) and beat counter cnt[CW-1:0]. Reset gives OWN0 and cnt=0.
//  - Combinational transfer: mX_ack = rst_n & (owner==X) & mX_req.
//    - br_addr and br_wdata come from the owner.
//    - br_we and br_be come from the owner, gated by that owner's ack.
//    - The owner's rdata = br_rdata. The non-owner's rdata = 0.
//  - While rst_n=0: all ack=0, br_we=0, br_be=0, owner=0.
//  - Idle owner (req low): br_we=0, br_be=0, addr/wdata still muxed from the owner.
//  - Latency: 0 cycles when the requester already owns the port. 1 cycle otherwise.
//  - Handshake: a master holds req/addr/wdata/we/be stable until it sees ack.
//    - A write commits at the clock edge that ends its acked cycle.
//    - A read uses rdata in the acked cycle.
//  - cnt_next = (owner acked this cycle) ? min(cnt+1, 2^CW-1) : cnt.
//  - Transitions, evaluated at each rising edge:
//    - OWN0 -> OWN1 if m1_req & (!m0_req | cnt_next >= M0_MAX_BEATS).
//    - OWN1 -> OWN0 if m0_req & (!m1_req | cnt_next >= M1_MAX_BEATS).
//    - Otherwise stay and cnt <= cnt_next. On any switch cnt <= 0.
//  - Simultaneous first requests after reset: M0 wins because it owns the port.
//  - No requests: owner parks where it is and cnt holds.
//  - Owner drops req while the other requests: switch at the next edge. One bubble cycle is allowed.
//  - Saturation: a long solo run saturates cnt. A late competing request then gets the port after at most one more owner beat.
//  - Reset mid-access: the access is aborted. No write commits on any edge while rst_n=0.
//  - No address decode here. Out-of-range behaviour belongs to Bridge. The arbiter only routes.
// TESTING
//  - Reset: assert rst_n=0 during an M1 write (m1_we=1, be=4'hF). Required: br_we=0, m1_ack=0, DM unchanged. After release: owner=0, cnt=0.
//  - M0 solo: m0_req=1 for 10 cycles with addr 0x0..0x24. Required: m0_ack=1 every cycle, br_addr tracks m0_addr with zero latency, owner stays 0.
//  - Contention: m0_req=m1_req=1 from cycle 0 after reset. Required:
//    - cycles 0-3 m0_ack=1;
//    - cycles 4-11 m1_ack=1;
//    - cycle 12 m0_ack=1 again.
//  - M1 solo from OWN0: m1_req rises at cycle 5 with addr 0x7F00, we=1, wdata=0x9. Required: m1_ack=0 at cycle 5, m1_ack=1 at cycle 6, timer0 sees the write at the cycle-6 edge.
//  - Early yield: M1 owns and drops req after 3 beats while m0_req=1. Required: owner=0 on the next cycle, cnt=0, no lost or duplicated beats.
//  - Read routing: M1 owns and reads while br_rdata=0xDEADBEEF. Required: m1_rdata=0xDEADBEEF, m0_rdata=0, m0_ack=0.

Source files
------------

// File: rtl/bridge_arbiter.sv
// bridge_arbiter
//   Shares the single Bridge port between the CPU memory stage (M0) and a
//   secondary bus master such as DMA or debug (M1). Only the owner and a
//   beat counter are registered; the transfer itself passes combinationally
//   from the owning master to the Bridge and back. Arbitration is bounded-
//   burst round-robin: an owner keeps the port while it is busy, but yields
//   to a waiting master after M0_MAX_BEATS / M1_MAX_BEATS acked beats.
//
// Ports
//   clk, rst_n                      clock (rising edge), async active-low reset
//   m0_req/addr/wdata/we/be         M0 request and payload
//   m0_ack, m0_rdata                M0 access done this cycle, read data
//   m1_req/addr/wdata/we/be         M1 request and payload
//   m1_ack, m1_rdata                M1 access done this cycle, read data
//   br_addr/wdata/we/be             to Bridge (owner's payload, we/be gated by ack)
//   br_rdata                        from Bridge
//   owner                           current owner, 0 = M0, 1 = M1
module bridge_arbiter #(
  parameter int M0_MAX_BEATS = 4,
  parameter int M1_MAX_BEATS = 8,
  parameter int CW           = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        m0_req,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  input  logic        m0_we,
  input  logic [3:0]  m0_be,
  output logic        m0_ack,
  output logic [31:0] m0_rdata,
  input  logic        m1_req,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  input  logic        m1_we,
  input  logic [3:0]  m1_be,
  output logic        m1_ack,
  output logic [31:0] m1_rdata,
  output logic [31:0] br_addr,
  output logic [31:0] br_wdata,
  output logic        br_we,
  output logic [3:0]  br_be,
  input  logic [31:0] br_rdata,
  output logic        owner
);

  typedef enum logic {
    OWN0 = 1'b0,
    OWN1 = 1'b1
  } own_t;

  localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};
  localparam logic [CW-1:0] M0_LIM  = CW'(M0_MAX_BEATS);
  localparam logic [CW-1:0] M1_LIM  = CW'(M1_MAX_BEATS);

  own_t          state_r;
  own_t          state_next_s;
  logic [CW-1:0] cnt_r;
  logic [CW-1:0] cnt_upd_s;
  logic [CW-1:0] cnt_next_s;
  logic          own_ack_s;
  logic          switch_s;

  // Route the owner's request to the Bridge and the Bridge's read data back.
  always_comb begin
    m0_ack   = 1'b0;
    m1_ack   = 1'b0;
    m0_rdata = 32'h0000_0000;
    m1_rdata = 32'h0000_0000;
    br_addr  = m0_addr;
    br_wdata = m0_wdata;
    br_we    = 1'b0;
    br_be    = 4'h0;
    if (state_r == OWN1) begin
      // rst_n in the ack keeps any write from reaching the Bridge during reset
      m1_ack   = rst_n & m1_req;
      br_addr  = m1_addr;
      br_wdata = m1_wdata;
      br_we    = m1_we & m1_ack;
      br_be    = m1_be & {4{m1_ack}};
      m1_rdata = br_rdata;
    end else begin
      m0_ack   = rst_n & m0_req;
      br_addr  = m0_addr;
      br_wdata = m0_wdata;
      br_we    = m0_we & m0_ack;
      br_be    = m0_be & {4{m0_ack}};
      m0_rdata = br_rdata;
    end
    owner = (state_r == OWN1);
  end

  // Beat counting and the owner hand-over decision.
  always_comb begin
    own_ack_s    = m0_ack | m1_ack;
    cnt_upd_s    = cnt_r;
    switch_s     = 1'b0;
    state_next_s = state_r;
    // Saturate so a long solo run cannot wrap and re-arm a fresh burst.
    if (own_ack_s && (cnt_r != CNT_MAX)) begin
      cnt_upd_s = cnt_r + CW'(1);
    end else begin
      cnt_upd_s = cnt_r;
    end
    case (state_r)
      OWN0: begin
        if (m1_req && (!m0_req || (cnt_upd_s >= M0_LIM))) begin
          switch_s     = 1'b1;
          state_next_s = OWN1;
        end else begin
          switch_s     = 1'b0;
          state_next_s = OWN0;
        end
      end
      OWN1: begin
        if (m0_req && (!m1_req || (cnt_upd_s >= M1_LIM))) begin
          switch_s     = 1'b1;
          state_next_s = OWN0;
        end else begin
          switch_s     = 1'b0;
          state_next_s = OWN1;
        end
      end
      default: begin
        switch_s     = 1'b0;
        state_next_s = OWN0;
      end
    endcase
    cnt_next_s = switch_s ? {CW{1'b0}} : cnt_upd_s;
  end

  // Owner and beat-counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= OWN0;
      cnt_r   <= {CW{1'b0}};
    end else begin
      state_r <= state_next_s;
      cnt_r   <= cnt_next_s;
    end
  end

endmodule
